// File: rtl/tspin_alert_timer.sv
`default_nettype none
// ============================================================================
// tspin_alert_timer: frame-aligned T-spin alert level with hold, retrigger
// and line-count latch. Optional blink enabled by macro TSPIN_BLINK_EN.
// Rev 1.0
// ============================================================================
module tspin_alert_timer #(
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       frame_tick,
    input  logic       tspin_pulse,
    input  logic [2:0] lines_cleared,
    input  logic       alert_clear,
    output logic       tspin_detected,
    output logic [2:0] tspin_lines
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic          pending, pending_nx;
    logic [2:0]    pending_lines, pending_lines_nx;
    logic [HW-1:0] hold_cnt, hold_cnt_nx;
    logic [2:0]    lines_nx;
    logic          detected_nx;
    logic [2:0]    lines_sat;
    logic          commit;

    assign lines_sat = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    assign commit    = frame_tick & (pending | tspin_pulse);

    always_comb begin
        state_nx         = state;
        pending_nx       = pending;
        pending_lines_nx = pending_lines;
        hold_cnt_nx      = hold_cnt;
        lines_nx         = tspin_lines;
        if (alert_clear) begin
            state_nx         = IDLE;
            pending_nx       = 1'b0;
            pending_lines_nx = 3'd0;
            hold_cnt_nx      = '0;
            lines_nx         = 3'd0;
        end else if (commit) begin
            // A pulse on the tick itself wins over an older pending event.
            state_nx    = SHOW;
            hold_cnt_nx = HOLD_LOAD;
            lines_nx    = tspin_pulse ? lines_sat : pending_lines;
            pending_nx  = 1'b0;
        end else begin
            if (tspin_pulse) begin
                pending_nx       = 1'b1;
                pending_lines_nx = lines_sat;
            end
            if (frame_tick && state == SHOW) begin
                if (hold_cnt == HW'(1)) begin
                    state_nx    = IDLE;
                    hold_cnt_nx = '0;
                    lines_nx    = 3'd0;
                end else begin
                    hold_cnt_nx = hold_cnt - HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state          <= IDLE;
            pending        <= 1'b0;
            pending_lines  <= 3'd0;
            hold_cnt       <= '0;
            tspin_detected <= 1'b0;
            tspin_lines    <= 3'd0;
        end else begin
            state          <= state_nx;
            pending        <= pending_nx;
            pending_lines  <= pending_lines_nx;
            hold_cnt       <= hold_cnt_nx;
            tspin_detected <= detected_nx;
            tspin_lines    <= lines_nx;
        end
    end

`ifdef TSPIN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic          phase, phase_nx;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;

    // Phase restarts high on every commit so a retrigger is always visible.
    always_comb begin
        phase_nx     = phase;
        blink_cnt_nx = blink_cnt;
        if (alert_clear || state_nx == IDLE) begin
            phase_nx     = 1'b1;
            blink_cnt_nx = '0;
        end else if (commit) begin
            phase_nx     = 1'b1;
            blink_cnt_nx = '0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                phase_nx     = ~phase;
                blink_cnt_nx = '0;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            phase     <= 1'b1;
            blink_cnt <= '0;
        end else begin
            phase     <= phase_nx;
            blink_cnt <= blink_cnt_nx;
        end
    end

    assign detected_nx = (state_nx == SHOW) & phase_nx;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign detected_nx      = (state_nx == SHOW);
`endif

endmodule
`default_nettype wire

// File: tb/tb_tspin_alert_timer.sv
`default_nettype none
// Bench for tspin_alert_timer: vector table, frame-level sequences and
// randomized traffic against an elapsed-frame reference model.
module tb_tspin_alert_timer;

    localparam int HOLD = 4;
    localparam int BF   = 2;
`ifdef TSPIN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       frame_tick = 1'b0;
    logic       tspin_pulse = 1'b0;
    logic [2:0] lines_cleared = 3'd0;
    logic       alert_clear = 1'b0;
    wire        tspin_detected;
    wire  [2:0] tspin_lines;

    tspin_alert_timer #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BF)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .frame_tick     (frame_tick),
        .tspin_pulse    (tspin_pulse),
        .lines_cleared  (lines_cleared),
        .alert_clear    (alert_clear),
        .tspin_detected (tspin_detected),
        .tspin_lines    (tspin_lines)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: alert visible while fewer than HOLD ticks have
    // elapsed since the commit tick.
    bit         m_active = 1'b0;
    bit         m_pend = 1'b0;
    logic [2:0] m_lines = 3'd0;
    logic [2:0] m_plines = 3'd0;
    int         m_frame = 0;
    int         m_commit = 0;

    function automatic logic [2:0] sat(input logic [2:0] l);
        return (l > 3'd4) ? 3'd4 : l;
    endfunction

    function automatic logic exp_det(input int e);
        return logic'((e >= 0) && (e < HOLD) && (!BLINK || ((e / BF) % 2 == 0)));
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic p,
                        input logic [2:0] l, input logic c);
        logic e_det;
        @(negedge clk);
        rst_l         = r;
        frame_tick    = t;
        tspin_pulse   = p;
        lines_cleared = l;
        alert_clear   = c;
        @(posedge clk);
        if (!r || c) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_lines  = 3'd0;
        end else begin
            if (t) m_frame++;
            if (t && (m_pend || p)) begin
                m_active = 1'b1;
                m_commit = m_frame;
                m_lines  = p ? sat(l) : m_plines;
                m_pend   = 1'b0;
            end else if (p) begin
                m_pend   = 1'b1;
                m_plines = sat(l);
            end
            if (m_active && (m_frame - m_commit) >= HOLD) begin
                m_active = 1'b0;
                m_lines  = 3'd0;
            end
        end
        e_det = m_active && exp_det(m_frame - m_commit);
        #1;
        check("model_det", {2'b0, tspin_detected}, {2'b0, e_det});
        check("model_lines", tspin_lines, m_lines);
    endtask

    // 50-cycle frame; tick on cycle 0, optional pulse/clear at given cycles.
    task automatic frame(input int pulse_at, input logic [2:0] l, input int clr_at,
                         output logic d_tick, output logic [2:0] l_tick);
        d_tick = 1'b0;
        l_tick = 3'd0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, i == 0, i == pulse_at, l, i == clr_at);
            if (i == 0) begin
                d_tick = tspin_detected;
                l_tick = tspin_lines;
            end
        end
    endtask

    typedef struct {
        logic       r, t, p;
        logic [2:0] l;
        logic       c;
        logic       d;
        logic [2:0] el;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic       d;
        logic [2:0] ln;
        int         gap;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, !BLINK, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, !BLINK, 3'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};

        // Reset held for 5 cycles with pulses present.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i == 2, 1'b1, 3'd2, 1'b0);
        end
        check("reset_det", {2'b0, tspin_detected}, 3'd0);
        check("reset_lines", tspin_lines, 3'd0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].p, tbl[i].l, tbl[i].c);
            check($sformatf("tbl%0d_det", i), {2'b0, tspin_detected}, {2'b0, tbl[i].d});
            check($sformatf("tbl%0d_lines", i), tspin_lines, tbl[i].el);
        end

        // Basic commit and hold-out across frames.
        frame(-1, 3'd0, -1, d, ln);
        check("s2_idle", {2'b0, d}, 3'd0);
        frame(10, 3'd2, -1, d, ln);
        check("s2_pre_tick", {2'b0, d}, 3'd0);
        for (int k = 0; k <= HOLD; k++) begin
            frame(-1, 3'd0, -1, d, ln);
            check($sformatf("s2_det_f%0d", k), {2'b0, d}, {2'b0, exp_det(k)});
            check($sformatf("s2_lines_f%0d", k), ln, (k < HOLD) ? 3'd2 : 3'd0);
        end

        // Retrigger during the second SHOW frame.
        frame(10, 3'd2, -1, d, ln);
        frame(-1, 3'd0, -1, d, ln);
        check("s3_commit_det", {2'b0, d}, 3'd1);
        frame(10, 3'd1, -1, d, ln);
        check("s3_f1_det", {2'b0, d}, {2'b0, exp_det(1)});
        check("s3_f1_lines", ln, 3'd2);
        for (int k = 0; k <= HOLD; k++) begin
            frame(-1, 3'd0, -1, d, ln);
            check($sformatf("s3_det_f%0d", k), {2'b0, d}, {2'b0, exp_det(k)});
            check($sformatf("s3_lines_f%0d", k), ln, (k < HOLD) ? 3'd1 : 3'd0);
        end

        // Clear mid-SHOW with a coincident pulse.
        frame(10, 3'd2, -1, d, ln);
        frame(-1, 3'd0, -1, d, ln);
        check("s4_commit_det", {2'b0, d}, 3'd1);
        frame(20, 3'd3, 20, d, ln);
        check("s4_after_clear", {2'b0, tspin_detected}, 3'd0);
        frame(-1, 3'd0, -1, d, ln);
        check("s4_no_reraise", {2'b0, d}, 3'd0);
        check("s4_lines", ln, 3'd0);

        // Pulse on the tick itself, then a saturating retrigger.
        frame(0, 3'd3, -1, d, ln);
        check("s5_det", {2'b0, d}, 3'd1);
        check("s5_lines", ln, 3'd3);
        frame(10, 3'd7, -1, d, ln);
        frame(-1, 3'd0, -1, d, ln);
        check("s5_sat_det", {2'b0, d}, 3'd1);
        check("s5_sat_lines", ln, 3'd4);
        for (int k = 0; k < HOLD; k++) frame(-1, 3'd0, -1, d, ln);

        // Randomized traffic with short frames.
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            logic t;
            t = (gap == 0);
            if (t) gap = $urandom_range(10, 2);
            else gap--;
            step(($urandom % 400) != 0, t, ($urandom % 12) == 0,
                 3'($urandom % 8), ($urandom % 150) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
